arm_dp_controller: RTL and testbench
====================================

// Module: arm_dp_controller
// PURPOSE
// - Multicycle control unit for the ARM data-processing subset: decodes the 32-bit IR
//   into register addresses, immediates, shifter/ALU op codes.
// - Sequences fetch -> operand read -> execute -> write-back with register-enable strobes.
// - Sits between fetch_instruction (IR, W_IR_valid) and registers/barrelshifter32/ALU.
//   Replaces the cpu-level `controller`.
// PARAMETERS
// - none (widths fixed by the ARM encoding)
// PORTS
// clk            in   1   system clock, single clock domain, rising-edge FSM
// rst            in   1   synchronous, active-low reset
// I              in   32  current instruction register
// W_IR_valid     in   1   1 = condition passed (from fetch unit)
// rd,rn,rm,rs    out  4   I[15:12], I[19:16], I[3:0], I[11:8]
// imm5           out  5   I[11:7]
// imm12          out  12  I[11:0]
// imm24          out  24  I[23:0]
// Und_Ins        out  1   undefined/unsupported instruction
// write_pc       out  1   PC update strobe
// write_ir       out  1   IR load strobe
// write_reg      out  1   register-file write strobe
// LA,LB,LC,LF    out  1   latch A(Rn), B(Rm), C(Rs), F(ALU result)
// S_ctrl         out  1   update NZCV
// rm_imm_s_ctrl  out  1   1 = shifter data is zero-extended imm12[7:0]
// rs_imm_s_ctrl  out  2   1x = amount imm5; 01 = amount C[7:0]; 00 = rotate-immediate
// Shift_OP_ctrl  out  3   {type, reg}; type 00 LSL, 01 LSR, 10 ASR, 11 ROR
// ALU_OP_ctrl    out  4   ARM opcode I[24:21]
// BEHAVIOUR
// - Field outputs (rd..imm24) are combinational slices of I, valid in every state.
// - Decode is combinational:
//   DPI: I[27:25]=001 -> rm_imm_s_ctrl=1, rs_imm_s_ctrl=00, Shift_OP=3'b111.
//   DPR: I[27:25]=000, I[4]=0 -> rm_imm_s_ctrl=0, rs_imm_s_ctrl=10, Shift_OP={I[6:5],0}.
//   DPRS: I[27:25]=000, I[7]=0, I[4]=1 -> rs_imm_s_ctrl=01, Shift_OP={I[6:5],1}.
//   B/BL: I[27:25]=101 -> recognised; no datapath activity (fetch unit uses imm24).
//   All else, incl. I[27:25]=000 with I[7]=I[4]=1 (MUL/LDRH space), -> Und_Ins=1.
// - FSM, Moore, states IDLE, FETCH, READ, EXEC, WB:
//   IDLE -> FETCH unconditionally.
//   FETCH (write_ir=1, write_pc=1) -> READ.
//   READ: if Und_Ins, !W_IR_valid, or B/BL -> FETCH. Else LA=LB=LC=1 -> EXEC.
//   EXEC: LF=1, S_ctrl=I[20] -> WB.
//   WB: write_reg=1 unless opcode is 10xx (TST/TEQ/CMP/CMN) -> FETCH.
// - Every strobe is 0 outside its listed state. Each instruction takes 1 FETCH cycle;
//   a DP instruction takes 4 cycles total.
// - rst=0 at a clk edge -> state IDLE; all strobes 0 next cycle. Applies in any state,
//   and mid-instruction reset discards the instruction.
// - Shift/ALU selects and ALU_OP_ctrl are driven from I in every state.
//   Consumers only sample them while enabled.
// STRUCTURE
// - Package arm_ctrl_pkg: state enum; opcode constants (AND..MVN); shift-type and
//   rs_imm_s_ctrl encodings.
// - Sub-module arm_instr_decode (pure combinational class/select decode).
//   The top holds the FSM and strobe logic.
// TESTING
// - Reset: hold rst=0 two cycles -> all strobes 0; release -> IDLE, then FETCH with
//   write_ir=write_pc=1.
// - I=0xE0821003 (ADD r1,r2,r3), W_IR_valid=1 -> rn=2,rd=1,rm=3; READ LA/LB/LC;
//   EXEC LF, S_ctrl=0; WB write_reg=1; ALU_OP=0100, Shift_OP=000, rs_imm_s_ctrl=10.
// - I=0xE3B000FF (MOVS r0,#0xFF) -> rm_imm_s_ctrl=1, rs_imm_s_ctrl=00, Shift_OP=111,
//   ALU_OP=1101, S_ctrl=1 in EXEC, write_reg=1 in WB.
// - I=0xE1510002 (CMP r1,r2) -> S_ctrl=1 in EXEC, write_reg stays 0 in WB.
// - I=0xE1A04615 (MOV r4,r5,LSL r6) -> rs=6, rs_imm_s_ctrl=01, Shift_OP=001.
// - I=0xE0000090 (MUL) -> Und_Ins=1, READ returns to FETCH with no LA/LF/write_reg.
//   Same skip for W_IR_valid=0 on ADD.
// - rst=0 asserted during EXEC -> no WB strobe; FSM restarts at IDLE.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM data-processing control unit.
package arm_ctrl_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned SHIFT_OP_W = 3;
  localparam int unsigned RS_SEL_W   = 2;
  localparam int unsigned CLASS_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

  // ARM data-processing opcodes, I[24:21]
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_EOR = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_RSB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_ADC = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SBC = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_RSC = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_TST = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_TEQ = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_CMP = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_CMN = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_ORR = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_MOV = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_BIC = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Shift-amount source select
  localparam logic [RS_SEL_W-1:0] RS_ROT_IMM = 2'b00;
  localparam logic [RS_SEL_W-1:0] RS_REG     = 2'b01;
  localparam logic [RS_SEL_W-1:0] RS_IMM5    = 2'b10;

  // Instruction class, I[27:25]
  localparam logic [CLASS_W-1:0] CLS_DP_REG = 3'b000;
  localparam logic [CLASS_W-1:0] CLS_DP_IMM = 3'b001;
  localparam logic [CLASS_W-1:0] CLS_BRANCH = 3'b101;

  typedef struct packed {
    logic                  und_ins;
    logic                  is_branch;
    logic                  rm_imm_s_ctrl;
    logic [RS_SEL_W-1:0]   rs_imm_s_ctrl;
    logic [SHIFT_OP_W-1:0] shift_op;
    logic [OPCODE_W-1:0]   alu_op;
  } decode_t;

  // Compare/test opcodes update flags only and never write Rd
  function automatic logic is_test_op(input logic [OPCODE_W-1:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/arm_dp_controller_if.sv
// Control-unit bus: IR/condition in from fetch, fields and strobes out to the datapath.
interface arm_dp_controller_if;
  import arm_ctrl_pkg::*;

  logic [INSTR_W-1:0]    I;
  logic                  W_IR_valid;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rn;
  logic [REG_ADDR_W-1:0] rm;
  logic [REG_ADDR_W-1:0] rs;
  logic [4:0]            imm5;
  logic [11:0]           imm12;
  logic [23:0]           imm24;
  logic                  Und_Ins;
  logic                  write_pc;
  logic                  write_ir;
  logic                  write_reg;
  logic                  LA;
  logic                  LB;
  logic                  LC;
  logic                  LF;
  logic                  S_ctrl;
  logic                  rm_imm_s_ctrl;
  logic [RS_SEL_W-1:0]   rs_imm_s_ctrl;
  logic [SHIFT_OP_W-1:0] Shift_OP_ctrl;
  logic [OPCODE_W-1:0]   ALU_OP_ctrl;

  modport master (
    output I, W_IR_valid,
    input  rd, rn, rm, rs, imm5, imm12, imm24, Und_Ins,
    input  write_pc, write_ir, write_reg, LA, LB, LC, LF, S_ctrl,
    input  rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl
  );

  modport slave (
    input  I, W_IR_valid,
    output rd, rn, rm, rs, imm5, imm12, imm24, Und_Ins,
    output write_pc, write_ir, write_reg, LA, LB, LC, LF, S_ctrl,
    output rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl
  );

endinterface

// File: rtl/arm_instr_decode.sv
// Combinational class decode and shifter/ALU select generation for one instruction.
module arm_instr_decode
  import arm_ctrl_pkg::*;
(
  input  logic [CLASS_W-1:0]  cls,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          shift_type,
  input  logic                bit7,
  input  logic                bit4,
  output decode_t             dec
);

  always_comb begin
    dec               = '0;
    dec.alu_op        = opcode;
    dec.rs_imm_s_ctrl = RS_IMM5;
    dec.shift_op      = {shift_type, 1'b0};
    case (cls)
      CLS_DP_IMM: begin
        dec.rm_imm_s_ctrl = 1'b1;
        dec.rs_imm_s_ctrl = RS_ROT_IMM;
        dec.shift_op      = 3'b111;
      end
      CLS_DP_REG: begin
        // bit4=1 with bit7=1 is the multiply / halfword-transfer space
        if (!bit4) begin
          dec.rs_imm_s_ctrl = RS_IMM5;
          dec.shift_op      = {shift_type, 1'b0};
        end else if (!bit7) begin
          dec.rs_imm_s_ctrl = RS_REG;
          dec.shift_op      = {shift_type, 1'b1};
        end else begin
          dec.und_ins = 1'b1;
        end
      end
      CLS_BRANCH: dec.is_branch = 1'b1;
      default:    dec.und_ins   = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_dp_controller.sv
// Multicycle FETCH/READ/EXEC/WB sequencer for ARM data-processing instructions.
module arm_dp_controller
  import arm_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  arm_dp_controller_if.slave  bus
);

  decode_t dec;
  state_t  state;
  logic    skip;
  logic    write_pc_q;
  logic    write_ir_q;
  logic    write_reg_q;
  logic    lf_q;
  logic    s_ctrl_q;

  arm_instr_decode u_decode (
    .cls        (bus.I[27:25]),
    .opcode     (bus.I[24:21]),
    .shift_type (bus.I[6:5]),
    .bit7       (bus.I[7]),
    .bit4       (bus.I[4]),
    .dec        (dec)
  );

  assign bus.rd    = bus.I[15:12];
  assign bus.rn    = bus.I[19:16];
  assign bus.rm    = bus.I[3:0];
  assign bus.rs    = bus.I[11:8];
  assign bus.imm5  = bus.I[11:7];
  assign bus.imm12 = bus.I[11:0];
  assign bus.imm24 = bus.I[23:0];

  assign bus.Und_Ins       = dec.und_ins;
  assign bus.rm_imm_s_ctrl = dec.rm_imm_s_ctrl;
  assign bus.rs_imm_s_ctrl = dec.rs_imm_s_ctrl;
  assign bus.Shift_OP_ctrl = dec.shift_op;
  assign bus.ALU_OP_ctrl   = dec.alu_op;

  // The IR is only loaded at the end of FETCH, so operand latching in READ
  // must follow the freshly loaded instruction rather than a registered copy.
  assign skip   = dec.und_ins | dec.is_branch | ~bus.W_IR_valid;
  assign bus.LA = (state == ST_READ) & ~skip;
  assign bus.LB = (state == ST_READ) & ~skip;
  assign bus.LC = (state == ST_READ) & ~skip;

  assign bus.write_pc  = write_pc_q;
  assign bus.write_ir  = write_ir_q;
  assign bus.write_reg = write_reg_q;
  assign bus.LF        = lf_q;
  assign bus.S_ctrl    = s_ctrl_q;

  // Strobes are loaded on the edge that enters the state they belong to
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      write_pc_q  <= 1'b0;
      write_ir_q  <= 1'b0;
      write_reg_q <= 1'b0;
      lf_q        <= 1'b0;
      s_ctrl_q    <= 1'b0;
    end else begin
      write_pc_q  <= 1'b0;
      write_ir_q  <= 1'b0;
      write_reg_q <= 1'b0;
      lf_q        <= 1'b0;
      s_ctrl_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          state      <= ST_FETCH;
          write_pc_q <= 1'b1;
          write_ir_q <= 1'b1;
        end
        ST_FETCH: state <= ST_READ;
        ST_READ: begin
          if (skip) begin
            state      <= ST_FETCH;
            write_pc_q <= 1'b1;
            write_ir_q <= 1'b1;
          end else begin
            state    <= ST_EXEC;
            lf_q     <= 1'b1;
            s_ctrl_q <= bus.I[20];
          end
        end
        ST_EXEC: begin
          state       <= ST_WB;
          write_reg_q <= ~is_test_op(dec.alu_op);
        end
        ST_WB: begin
          state      <= ST_FETCH;
          write_pc_q <= 1'b1;
          write_ir_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_dp_controller.sv
// Directed-vector bench for arm_dp_controller with hand-computed expectations.
module tb_arm_dp_controller;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  arm_dp_controller_if dp_if ();

  arm_dp_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {write_pc, write_ir, write_reg, LA, LB, LC, LF, S_ctrl}
  function automatic logic [7:0] strobes();
    return {dp_if.write_pc, dp_if.write_ir, dp_if.write_reg,
            dp_if.LA, dp_if.LB, dp_if.LC, dp_if.LF, dp_if.S_ctrl};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a FETCH-state negedge with I already applied; ends at the next FETCH.
  task automatic run_dp(input string tag, input logic [7:0] exec_exp, input logic [7:0] wb_exp);
    @(negedge clk); check({tag, "_read"}, 32'(strobes()), 32'h1C);
    @(negedge clk); check({tag, "_exec"}, 32'(strobes()), 32'(exec_exp));
    @(negedge clk); check({tag, "_wb"},   32'(strobes()), 32'(wb_exp));
    @(negedge clk); check({tag, "_fetch"}, 32'(strobes()), 32'hC0);
  endtask

  task automatic run_skip(input string tag);
    @(negedge clk); check({tag, "_read"},  32'(strobes()), 32'h00);
    @(negedge clk); check({tag, "_fetch"}, 32'(strobes()), 32'hC0);
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst              = 1'b0;
    dp_if.I          = 32'h0;
    dp_if.W_IR_valid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_strobes", 32'(strobes()), 32'h00);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_fetch", 32'(strobes()), 32'hC0);

    // ADD r1,r2,r3
    dp_if.I = 32'hE0821003; dp_if.W_IR_valid = 1'b1;
    #1;
    check("add_rn",     32'(dp_if.rn), 32'd2);
    check("add_rd",     32'(dp_if.rd), 32'd1);
    check("add_rm",     32'(dp_if.rm), 32'd3);
    check("add_rs",     32'(dp_if.rs), 32'd0);
    check("add_imm12",  32'(dp_if.imm12), 32'h003);
    check("add_imm24",  32'(dp_if.imm24), 32'h821003);
    check("add_alu",    32'(dp_if.ALU_OP_ctrl), 32'h4);
    check("add_shift",  32'(dp_if.Shift_OP_ctrl), 32'h0);
    check("add_rssel",  32'(dp_if.rs_imm_s_ctrl), 32'h2);
    check("add_rmimm",  32'(dp_if.rm_imm_s_ctrl), 32'h0);
    check("add_und",    32'(dp_if.Und_Ins), 32'h0);
    run_dp("add", 8'h02, 8'h20);

    // MOVS r0,#0xFF
    dp_if.I = 32'hE3B000FF;
    #1;
    check("movs_rmimm", 32'(dp_if.rm_imm_s_ctrl), 32'h1);
    check("movs_rssel", 32'(dp_if.rs_imm_s_ctrl), 32'h0);
    check("movs_shift", 32'(dp_if.Shift_OP_ctrl), 32'h7);
    check("movs_alu",   32'(dp_if.ALU_OP_ctrl), 32'hD);
    check("movs_imm12", 32'(dp_if.imm12), 32'h0FF);
    run_dp("movs", 8'h03, 8'h20);

    // CMP r1,r2: flags only, no register write
    dp_if.I = 32'hE1510002;
    #1;
    check("cmp_alu", 32'(dp_if.ALU_OP_ctrl), 32'hA);
    check("cmp_rn",  32'(dp_if.rn), 32'd1);
    run_dp("cmp", 8'h03, 8'h00);

    // MOV r4,r5,LSL r6
    dp_if.I = 32'hE1A04615;
    #1;
    check("movr_rs",    32'(dp_if.rs), 32'd6);
    check("movr_rd",    32'(dp_if.rd), 32'd4);
    check("movr_rm",    32'(dp_if.rm), 32'd5);
    check("movr_imm5",  32'(dp_if.imm5), 32'd12);
    check("movr_rssel", 32'(dp_if.rs_imm_s_ctrl), 32'h1);
    check("movr_shift", 32'(dp_if.Shift_OP_ctrl), 32'h1);
    check("movr_rmimm", 32'(dp_if.rm_imm_s_ctrl), 32'h0);
    run_dp("movr", 8'h02, 8'h20);

    // MUL space is undefined
    dp_if.I = 32'hE0000090;
    #1;
    check("mul_und", 32'(dp_if.Und_Ins), 32'h1);
    run_skip("mul");

    // LDR class is unsupported
    dp_if.I = 32'hE5912000;
    #1;
    check("ldr_und", 32'(dp_if.Und_Ins), 32'h1);
    run_skip("ldr");

    // Branch: recognised, but no datapath activity
    dp_if.I = 32'hEA000010;
    #1;
    check("b_und",   32'(dp_if.Und_Ins), 32'h0);
    check("b_imm24", 32'(dp_if.imm24), 32'h000010);
    run_skip("b");

    // Condition failed on ADD
    dp_if.I = 32'hE0821003; dp_if.W_IR_valid = 1'b0;
    run_skip("add_nv");
    dp_if.W_IR_valid = 1'b1;

    // Reset during EXEC discards the instruction
    @(negedge clk); check("rexec_read", 32'(strobes()), 32'h1C);
    @(negedge clk); check("rexec_exec", 32'(strobes()), 32'h02);
    rst = 1'b0;
    @(negedge clk); check("rexec_idle", 32'(strobes()), 32'h00);
    rst = 1'b1;
    @(negedge clk); check("rexec_fetch", 32'(strobes()), 32'hC0);
    run_dp("add_after_rst", 8'h02, 8'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
